// File: rtl/addsub_pkg.sv
// Shared encodings and stage payload for the pipelined add/subtract unit.
// The payload is sized for the widest legal operand; narrower instances use the low bits.
package addsub_pkg;

  localparam int MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_ADDC = 2'b10,
    OP_SBB  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    SAT_WRAP     = 2'b00,
    SAT_U        = 2'b01,
    SAT_S        = 2'b10,
    SAT_WRAP_ALT = 2'b11
  } sat_e;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
    logic                 zero;
    logic                 satd;
  } payload_t;

  function automatic logic is_subtract(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

endpackage

// File: rtl/pipelined_addsub_core.sv
// Combinational first-stage arithmetic: operand conditioning, add, flags and saturation.
module addsub_core
  import addsub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [1:0]       sat,
  output payload_t         res
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] final_sum;
  logic             sub;
  logic             c0;
  logic             carry_out;
  logic             ovf_raw;
  logic             sat_hit;

  // Subtraction is A + ~B + 1 (or + cin for SBB), so carry out of 1 means "no borrow".
  always_comb begin
    sub = is_subtract(op);
    bx  = sub ? ~b : b;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    {carry_out, raw} = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, c0};
    ovf_raw = (a[WIDTH-1] == bx[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    final_sum = raw;
    sat_hit   = 1'b0;
    case (sat)
      SAT_U: begin
        if (sub && !carry_out) begin
          final_sum = '0;
          sat_hit   = 1'b1;
        end else if (!sub && carry_out) begin
          final_sum = '1;
          sat_hit   = 1'b1;
        end
      end
      SAT_S: begin
        // On signed overflow the sign of A tells which rail was crossed.
        if (ovf_raw) begin
          final_sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
          sat_hit   = 1'b1;
        end
      end
      default: begin
        final_sum = raw;
        sat_hit   = 1'b0;
      end
    endcase
  end

  always_comb begin
    res       = '0;
    res.sum   = MAX_WIDTH'(final_sum);
    res.carry = carry_out;
    res.ovf   = ovf_raw;
    res.zero  = (final_sum == '0);
    res.satd  = sat_hit;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract with saturation modes and a valid/ready handshake.
// All stages advance together; a stalled output freezes the whole pipeline.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  input  logic [1:0]       op,
  input  logic [1:0]       sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             carry,
  output logic             ovf,
  output logic             zero,
  output logic             satd
);

  payload_t           core_res;
  payload_t           stage_data [LATENCY];
  logic [LATENCY-1:0] stage_valid;
  logic               advance;

  addsub_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a   (A),
    .b   (B),
    .cin (cin),
    .op  (op),
    .sat (sat),
    .res (core_res)
  );

  assign advance   = out_ready | ~out_valid;
  assign in_ready  = advance;
  assign out_valid = stage_valid[LATENCY-1];

  // Stage 0 captures the arithmetic result; later stages only delay it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stage_data[i] <= '0;
      end
    end else if (advance) begin
      stage_valid[0] <= in_valid;
      stage_data[0]  <= core_res;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_data[i]  <= stage_data[i-1];
      end
    end
  end

  assign Sum   = stage_data[LATENCY-1].sum[WIDTH-1:0];
  assign carry = stage_data[LATENCY-1].carry;
  assign ovf   = stage_data[LATENCY-1].ovf;
  assign zero  = stage_data[LATENCY-1].zero;
  assign satd  = stage_data[LATENCY-1].satd;

  generate
    if (WIDTH < MAX_WIDTH) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^stage_data[LATENCY-1].sum[MAX_WIDTH-1:WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_pipelined_addsub.sv
// Self-checking bench: directed table, handshake corner sequences and a randomized
// scoreboard run against an arithmetic reference model.
module tb_pipelined_addsub;
  import addsub_pkg::*;

  localparam int WIDTH   = 8;
  localparam int LATENCY = 2;

  typedef struct packed {
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
    logic       zero;
    logic       satd;
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] sat;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    exp_t       e;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             cin;
  logic [1:0]       op;
  logic [1:0]       sat;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Sum;
  logic             carry;
  logic             ovf;
  logic             zero;
  logic             satd;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  bit   rand_ready = 0;
  bit   stalled = 0;
  logic [7:0] held_sum;
  exp_t mon_e;
  vec_t vecs [12];

  pipelined_addsub #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .op        (op),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Sum       (Sum),
    .carry     (carry),
    .ovf       (ovf),
    .zero      (zero),
    .satd      (satd)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the mathematical values.
  function automatic exp_t refModel(input logic [7:0] a, input logic [7:0] b, input logic c_in,
                                    input logic [1:0] o, input logic [1:0] s);
    exp_t e;
    int ua, ub, sa, sb, c, u, sv;
    bit subtract;
    ua = a;
    ub = b;
    sa = $signed(a);
    sb = $signed(b);
    subtract = (o == 2'd1) || (o == 2'd3);
    c = (o == 2'd0) ? 0 : (o == 2'd1) ? 1 : int'(c_in);
    if (!subtract) begin
      u = ua + ub + c;
      sv = sa + sb + c;
      e.carry = (u > 255);
    end else begin
      u = ua - ub - (1 - c);
      sv = sa - sb - (1 - c);
      e.carry = (u >= 0);
    end
    e.ovf  = (sv > 127) || (sv < -128);
    e.sum  = 8'(u);
    e.satd = 1'b0;
    if (s == 2'd1) begin
      if (!subtract && e.carry) begin e.sum = 8'hFF; e.satd = 1'b1; end
      if (subtract && !e.carry) begin e.sum = 8'h00; e.satd = 1'b1; end
    end else if (s == 2'd2 && e.ovf) begin
      e.sum  = (sa < 0) ? 8'h80 : 8'h7F;
      e.satd = 1'b1;
    end
    e.zero = (e.sum == 8'h00);
    return e;
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if ({Sum, carry, ovf, zero, satd} !== e) begin
      errors++;
      $display("[TB] FAIL %s: got sum=%h c=%b v=%b z=%b s=%b, expected sum=%h c=%b v=%b z=%b s=%b",
               name, Sum, carry, ovf, zero, satd, e.sum, e.carry, e.ovf, e.zero, e.satd);
    end
  endtask

  // Presents one beat, holds it until accepted, then records its expected result.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input logic c_in,
                               input logic [1:0] o, input logic [1:0] s, input exp_t e);
    int guard = 0;
    in_valid = 1'b1;
    A = a; B = b; cin = c_in; op = o; sat = s;
    do begin
      @(negedge clk);
      guard++;
    end while (!in_ready && guard < 100);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: in_ready stuck at %b, expected 1", in_ready);
    end else begin
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    checkValue(name, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard on transfers, data stability while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 0;
    end else begin
      if (stalled && out_valid) checkValue("stall_stable_sum", Sum, held_sum);
      stalled  = out_valid && !out_ready;
      held_sum = Sum;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got sum=%h, expected no beat", Sum);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("result", mon_e);
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    // Directed vectors: {op, sat, a, b, cin, {sum, carry, ovf, zero, satd}}
    vecs[0]  = '{OP_ADD,  SAT_WRAP,     8'h01, 8'h02, 1'b0, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1]  = '{OP_ADD,  SAT_WRAP,     8'hFF, 8'h01, 1'b0, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[2]  = '{OP_ADD,  SAT_U,        8'hF0, 8'h20, 1'b0, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[3]  = '{OP_SUB,  SAT_U,        8'h10, 8'h20, 1'b0, '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[4]  = '{OP_ADD,  SAT_S,        8'h70, 8'h20, 1'b0, '{8'h7F, 1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[5]  = '{OP_SUB,  SAT_S,        8'h80, 8'h01, 1'b0, '{8'h80, 1'b1, 1'b1, 1'b0, 1'b1}};
    vecs[6]  = '{OP_ADDC, SAT_WRAP,     8'h01, 8'h01, 1'b1, '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7]  = '{OP_SBB,  SAT_WRAP,     8'h05, 8'h03, 1'b0, '{8'h01, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[8]  = '{OP_ADD,  SAT_WRAP_ALT, 8'h01, 8'h01, 1'b1, '{8'h02, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[9]  = '{OP_SUB,  SAT_S,        8'h05, 8'h03, 1'b0, '{8'h02, 1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[10] = '{OP_ADDC, SAT_U,        8'hFF, 8'hFF, 1'b1, '{8'hFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[11] = '{OP_ADD,  SAT_U,        8'h10, 8'h20, 1'b0, '{8'h30, 1'b0, 1'b0, 1'b0, 1'b0}};

    rst_n = 1'b0;
    in_valid = 1'b1;
    A = 8'($urandom); B = 8'($urandom); cin = 1'b1; op = OP_ADD; sat = SAT_WRAP;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("reset_out_valid", out_valid, 0);
    checkValue("reset_outputs", {Sum, carry, ovf, zero, satd}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    in_valid = 1'b0;

    // First accepted beat: out_valid must rise exactly LATENCY cycles later.
    applyStimulus(8'h11, 8'h22, 1'b0, OP_ADD, SAT_WRAP, '{8'h33, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    checkValue("latency_early", out_valid, 0);
    @(negedge clk);
    checkValue("latency_exact", out_valid, 1);
    @(posedge clk);
    #1;

    // Back-to-back beats give back-to-back outputs.
    applyStimulus(vecs[0].a, vecs[0].b, vecs[0].cin, vecs[0].op, vecs[0].sat, vecs[0].e);
    applyStimulus(vecs[1].a, vecs[1].b, vecs[1].cin, vecs[1].op, vecs[1].sat, vecs[1].e);
    @(negedge clk);
    checkValue("b2b_first_valid", out_valid, 1);
    @(negedge clk);
    checkValue("b2b_second_valid", out_valid, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op, vecs[i].sat, vecs[i].e);
    end
    waitDrain("table_drain");

    // Backpressure: four beats while the consumer stalls.
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          applyStimulus(8'(i + 1), 8'(16 * i), 1'b0, OP_ADD, SAT_WRAP,
                        refModel(8'(i + 1), 8'(16 * i), 1'b0, OP_ADD, SAT_WRAP));
        end
      end
      begin
        int guard = 0;
        while (!out_valid && guard < 20) begin
          @(negedge clk);
          guard++;
        end
        checkValue("stall_out_valid", out_valid, 1);
        checkValue("stall_in_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("stall_drain");

    // Reset while stalled with beats in flight.
    out_ready = 1'b0;
    applyStimulus(8'h21, 8'h01, 1'b0, OP_ADD, SAT_WRAP, refModel(8'h21, 8'h01, 1'b0, OP_ADD, SAT_WRAP));
    applyStimulus(8'h31, 8'h01, 1'b0, OP_ADD, SAT_WRAP, refModel(8'h31, 8'h01, 1'b0, OP_ADD, SAT_WRAP));
    checkValue("pre_reset_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkValue("midreset_out_valid", out_valid, 0);
    checkValue("midreset_sum", Sum, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    checkValue("post_reset_empty", out_valid, 0);
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure against the reference model.
    rand_ready = 1;
    for (int n = 0; n < 300; n++) begin
      logic [7:0] ra, rb;
      logic       rc;
      logic [1:0] ro, rs;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      ro = 2'($urandom);
      rs = 2'($urandom);
      applyStimulus(ra, rb, rc, ro, rs, refModel(ra, rb, rc, ro, rs));
    end
    rand_ready = 0;
    repeat (2) @(posedge clk);
    #2;
    out_ready = 1'b1;
    waitDrain("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined successor to the 8-bit registered adder.
- Adds or subtracts two WIDTH-bit operands, with optional carry-in.
- Selectable wrap, unsigned-saturate or signed-saturate result modes; produces carry, overflow, zero and saturated flags.
- Valid/ready handshake on both sides with backpressure; sits between the register file and the writeback stage of the datapath.

Parameters:
- WIDTH, 8: operand and result width in bits; legal range 2..32.
- LATENCY, 2: pipeline register stages from input to output; legal range 1..4.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- cin  in  1  carry/not-borrow input; used only by ADDC and SBB.
- op  in  2  operation: 00 ADD, 01 SUB, 10 ADDC, 11 SBB.
- sat  in  2  result mode: 00 WRAP, 01 USAT, 10 SSAT, 11 WRAP.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result.
- Sum  out  WIDTH  result.
- carry  out  1  raw carry out of the MSB; for subtract, 1 means no borrow.
- ovf  out  1  raw signed overflow, before saturation.
- zero  out  1  Sum == 0, evaluated after saturation.
- satd  out  1  saturation altered the result.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values: all stage valid bits 0; out_valid 0; Sum, carry, ovf, zero, satd all 0.
- Reset asserted mid-operation: all in-flight beats are dropped immediately.
- in_ready is combinational after reset.

Handshake:
- advance = out_ready | ~out_valid; in_ready = advance.
- A beat is accepted when in_valid & in_ready.
- On advance, every stage shifts forward one position.
- A stage is loaded with valid = in_valid & in_ready; bubbles propagate as valid = 0.
- When advance = 0, all stages hold, including data.
- Accepted-to-out_valid latency is exactly LATENCY cycles when out_ready is held high.
- Full throughput: one beat per cycle when out_ready is high.
- Output data is stable while out_valid & ~out_ready.
- A result is transferred on out_valid & out_ready.

Arithmetic (stage 1, all combinational before the first register):
- Bx = B for ADD and ADDC; Bx = ~B for SUB and SBB.
- c0 = 0 for ADD, 1 for SUB, cin for ADDC and SBB.
- {carry, R} = A + Bx + c0, computed at WIDTH+1 bits.
- ovf = (A[MSB] == Bx[MSB]) & (R[MSB] != A[MSB]).

Result modes:
- WRAP: Sum = R; satd = 0.
- USAT: ADD/ADDC with carry = 1 gives Sum = all ones. SUB/SBB with carry = 0 gives Sum = 0. In both cases satd = 1; otherwise Sum = R.
- SSAT: if ovf, Sum = A[MSB] ? {1,0...0} : {0,1...1} and satd = 1; otherwise Sum = R.
- zero is computed on the final Sum.
- Stages 2..LATENCY delay data and flags only.

Decomposition:
- Shared package addsub_pkg holds:
  - op encodings OP_ADD, OP_SUB, OP_ADDC, OP_SBB;
  - mode encodings SAT_WRAP, SAT_U, SAT_S;
  - a packed struct for the stage payload {Sum, carry, ovf, zero, satd}.
- One sub-module, addsub_core: the combinational stage-1 arithmetic and saturation.
- The top level holds the valid/data pipeline and the handshake.

Test Plan (WIDTH=8, LATENCY=2):
- Reset: hold rst_n=0 with in_valid=1 and random operands -> out_valid=0 and all outputs 0. Release rst_n -> first result appears exactly 2 cycles after the first accepted beat.
- ADD wrap: A=0x01, B=0x02 -> Sum=0x03, carry=0. Then A=0xFF, B=0x01 -> Sum=0x00, carry=1, zero=1. Back-to-back beats give back-to-back outputs.
- USAT: ADD A=0xF0, B=0x20 -> Sum=0xFF, satd=1. SUB A=0x10, B=0x20 -> Sum=0x00, carry=0, satd=1.
- SSAT: ADD A=0x70, B=0x20 -> Sum=0x7F, ovf=1. SUB A=0x80, B=0x01 -> Sum=0x80, ovf=1, satd=1.
- ADDC/SBB: ADDC A=0x01, B=0x01, cin=1 -> Sum=0x03. SBB A=0x05, B=0x03, cin=0 -> Sum=0x01, carry=1.
- Backpressure: stream 4 beats with out_ready=0 for 3 cycles:
  - in_ready drops once the pipeline fills;
  - Sum stays stable while stalled;
  - all 4 results are delivered in order with none lost or duplicated.
- Reset asserted mid-stall -> pipeline empties, out_valid=0.
